// File: rtl/mem_lsu_pkg.sv
// Shared op codes, bus widths and FSM encoding for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;

  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;
  localparam logic [31:0]           ZERO_WORD    = 32'h0000_0000;

  localparam logic [ALU_OP_W-1:0] MEM_NOP = 8'h00;
  localparam logic [ALU_OP_W-1:0] MEM_LB  = 8'h20;
  localparam logic [ALU_OP_W-1:0] MEM_LH  = 8'h21;
  localparam logic [ALU_OP_W-1:0] MEM_LW  = 8'h23;
  localparam logic [ALU_OP_W-1:0] MEM_LBU = 8'h24;
  localparam logic [ALU_OP_W-1:0] MEM_LHU = 8'h25;
  localparam logic [ALU_OP_W-1:0] MEM_SB  = 8'h28;
  localparam logic [ALU_OP_W-1:0] MEM_SH  = 8'h29;
  localparam logic [ALU_OP_W-1:0] MEM_SW  = 8'h2B;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_XFER,
    LSU_LAST,
    LSU_DONE
  } lsu_state_e;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Index of the final byte of the access (N-1).
  function automatic logic [1:0] last_byte(input logic [ALU_OP_W-1:0] op);
    logic [1:0] idx;
    idx = 2'd0;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) idx = 2'd1;
    if (op == MEM_LW || op == MEM_SW) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// Sign/zero extension of the assembled load buffer according to the load op.
module mem_ext
  import mem_lsu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [31:0]         buf_i,
  output logic [31:0]         result_o
);

  always_comb begin
    result_o = buf_i;
    case (op_i)
      MEM_LB:  result_o = {{24{buf_i[7]}}, buf_i[7:0]};
      MEM_LBU: result_o = {24'd0, buf_i[7:0]};
      MEM_LH:  result_o = {{16{buf_i[15]}}, buf_i[15:0]};
      MEM_LHU: result_o = {16'd0, buf_i[15:0]};
      default: result_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-serial RAM accesses behind a req/gnt
// handshake, stalling the pipeline until the access completes.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [RAM_AW-1:0]     ram_a_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;

  logic        op_ld, op_st, op_mem;
  logic [1:0]  last_k;
  logic [31:0] byte_addr;
  logic [31:0] ext_result;
  logic        unused_addr_hi;

  assign op_ld     = is_load(aluop_i);
  assign op_st     = is_store(aluop_i);
  assign op_mem    = op_ld | op_st;
  assign last_k    = last_byte(aluop_i);
  assign byte_addr = mem_addr_i + {30'd0, k_q};

  assign unused_addr_hi = ^byte_addr[31:RAM_AW];

  mem_ext u_ext (
    .op_i     (aluop_i),
    .buf_i    (buf_q),
    .result_o (ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= LSU_IDLE;
      k_q     <= 2'd0;
      buf_q   <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

  // Read data lags its address by one cycle, so XFER k captures byte k-1
  // and LAST captures the final byte.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
    case (state_q)
      LSU_IDLE: begin
        if (op_mem) begin
          state_d = LSU_WAIT;
          k_d     = 2'd0;
          buf_d   = ZERO_WORD;
        end
      end
      LSU_WAIT: begin
        if (gnt_i) begin
          state_d = LSU_XFER;
          k_d     = 2'd0;
        end
      end
      LSU_XFER: begin
        if (op_ld && (k_q != 2'd0)) buf_d[{k_q - 2'd1, 3'b000} +: 8] = ram_din_i;
        if (k_q == last_k) state_d = op_st ? LSU_DONE : LSU_LAST;
        else               k_d     = k_q + 2'd1;
      end
      LSU_LAST: begin
        buf_d[{k_q, 3'b000} +: 8] = ram_din_i;
        state_d = LSU_DONE;
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
        k_d     = 2'd0;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_o      = 1'b0;
    stall_o    = 1'b0;
    ram_a_o    = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    wd_o       = wd_i;
    wreg_o     = 1'b0;
    wdata_o    = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      wd_o = NOP_REG_ADDR;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (op_mem) begin
            stall_o = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        LSU_WAIT, LSU_LAST: begin
          req_o   = 1'b1;
          stall_o = 1'b1;
        end
        LSU_XFER: begin
          req_o   = 1'b1;
          stall_o = 1'b1;
          ram_a_o = byte_addr[RAM_AW-1:0];
          if (op_st) begin
            ram_wr_o   = 1'b1;
            ram_dout_o = wdata_i[{k_q, 3'b000} +: 8];
          end
        end
        LSU_DONE: begin
          if (op_ld) begin
            wreg_o  = wreg_i && (wd_i != NOP_REG_ADDR);
            wdata_o = ext_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
